// File: rtl/tile_scatter_loader_if.sv
// Handshake/bus bundle between the loader, its controller, the global buffer and the tile BRAMs.
// The master side is the controller plus global buffer; the slave side is the loader itself.
interface tile_scatter_loader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int TADDR_WIDTH = 4,
  parameter int NUM_TILES   = 16
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic                   stall;
  logic                   g_rd_en;
  logic [ADDR_WIDTH-1:0]  g_rd_addr;
  logic [DATA_WIDTH-1:0]  g_rd_data;
  logic [NUM_TILES-1:0]   tile_wr_en;
  logic [TADDR_WIDTH-1:0] tile_addr;
  logic [DATA_WIDTH-1:0]  tile_data;
  logic                   busy;
  logic                   done;

  modport master (
    output start, base_addr, stall, g_rd_data,
    input  g_rd_en, g_rd_addr, tile_wr_en, tile_addr, tile_data, busy, done
  );

  modport slave (
    input  start, base_addr, stall, g_rd_data,
    output g_rd_en, g_rd_addr, tile_wr_en, tile_addr, tile_data, busy, done
  );
endinterface

// File: rtl/tile_scatter_loader.sv
// Reads a MAT_DIM x MAT_DIM row-major matrix from the global buffer and scatters each
// word into the tile BRAM that owns it, one word per cycle with a 1-deep read pipeline.
module tile_scatter_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int TILE_SIZE   = 4,
  parameter int MAT_DIM     = 16,
  parameter int NUM_TILES   = 16,
  parameter int ADDR_WIDTH  = 9,
  parameter int TADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tile_scatter_loader_if.slave bus
);
  localparam int TPR = MAT_DIM / TILE_SIZE;
  localparam int IW  = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int TW  = (TPR > 1) ? $clog2(TPR) : 1;
  localparam int TIW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [IW-1:0]          col_in_reg, row_in_reg;
  logic [TW-1:0]          col_tile_reg, row_tile_reg;
  logic                   valid_reg;
  logic [TIW-1:0]         wr_tile_reg;
  logic [TADDR_WIDTH-1:0] wr_off_reg;

  logic                   issue;
  logic                   col_last;
  logic                   row_last;
  logic                   last_issue;
  logic [TIW-1:0]         tile_idx;
  logic [TADDR_WIDTH-1:0] tile_off;
  logic [NUM_TILES-1:0]   wr_en_vec;
  logic [DATA_WIDTH-1:0]  rd_data;

  assign issue      = (state_reg == READ) && !bus.stall;
  assign col_last   = (col_in_reg == IW'(TILE_SIZE - 1)) && (col_tile_reg == TW'(TPR - 1));
  assign row_last   = (row_in_reg == IW'(TILE_SIZE - 1)) && (row_tile_reg == TW'(TPR - 1));
  assign last_issue = issue && col_last && row_last;

  // Tile/offset come from the sub-counters, so only constant multiplies remain.
  assign tile_idx = TIW'(int'(row_tile_reg) * TPR + int'(col_tile_reg));
  assign tile_off = TADDR_WIDTH'(int'(row_in_reg) * TILE_SIZE + int'(col_in_reg));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = READ;
      READ:    if (last_issue) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      col_in_reg   <= '0;
      row_in_reg   <= '0;
      col_tile_reg <= '0;
      row_tile_reg <= '0;
      valid_reg    <= 1'b0;
      wr_tile_reg  <= '0;
      wr_off_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= issue;
      if (issue) begin
        wr_tile_reg <= tile_idx;
        wr_off_reg  <= tile_off;
      end
      if (state_reg == IDLE && bus.start) begin
        addr_reg     <= bus.base_addr;
        col_in_reg   <= '0;
        row_in_reg   <= '0;
        col_tile_reg <= '0;
        row_tile_reg <= '0;
      end else if (issue) begin
        // Linear address wraps naturally modulo 2^ADDR_WIDTH.
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
        if (col_in_reg == IW'(TILE_SIZE - 1)) begin
          col_in_reg <= '0;
          if (col_tile_reg == TW'(TPR - 1)) begin
            col_tile_reg <= '0;
            if (row_in_reg == IW'(TILE_SIZE - 1)) begin
              row_in_reg   <= '0;
              row_tile_reg <= row_tile_reg + TW'(1);
            end else begin
              row_in_reg <= row_in_reg + IW'(1);
            end
          end else begin
            col_tile_reg <= col_tile_reg + TW'(1);
          end
        end else begin
          col_in_reg <= col_in_reg + IW'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_wr_en
    assign wr_en_vec[gi] = valid_reg && (wr_tile_reg == TIW'(gi));
  end

  assign rd_data        = bus.g_rd_data;
  assign bus.g_rd_en    = issue;
  assign bus.g_rd_addr  = issue ? addr_reg : '0;
  assign bus.tile_wr_en = wr_en_vec;
  assign bus.tile_addr  = valid_reg ? wr_off_reg : '0;
  assign bus.tile_data  = valid_reg ? rd_data : '0;
  assign bus.busy       = (state_reg == READ) || (state_reg == DRAIN);
  assign bus.done       = (state_reg == DONE);
endmodule

// File: tb/tb_tile_scatter_loader.sv
// Directed bench for tile_scatter_loader: a global-buffer model plus read/write scoreboards
// filled when each load is launched and drained by a negedge monitor.
module tb_tile_scatter_loader;
  localparam int DW = 32;
  localparam int TS = 4;
  localparam int MD = 16;
  localparam int NT = 16;
  localparam int AW = 9;
  localparam int TAW = 4;

  typedef struct {
    int          tile;
    int          off;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  bit   mon_en;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int  rd_q [$];
  wr_t wr_q [$];

  tile_scatter_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TADDR_WIDTH(TAW), .NUM_TILES(NT)) bus ();

  tile_scatter_loader #(
    .DATA_WIDTH(DW), .TILE_SIZE(TS), .MAT_DIM(MD), .NUM_TILES(NT),
    .ADDR_WIDTH(AW), .TADDR_WIDTH(TAW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global buffer: data is valid exactly one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.g_rd_en) bus.g_rd_data <= mem[bus.g_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_expect(input int base);
    for (int k = 0; k < MD*MD; k++) begin
      int  r;
      int  c;
      int  a;
      wr_t e;
      r = k / MD;
      c = k % MD;
      a = (base + k) % (1 << AW);
      e.tile = (r / TS) * (MD / TS) + c / TS;
      e.off  = (r % TS) * TS + c % TS;
      e.data = mem[a];
      rd_q.push_back(a);
      wr_q.push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"},   32'(bus.g_rd_en), 0);
    check({tag, "_rd_addr"}, 32'(bus.g_rd_addr), 0);
    check({tag, "_wr_en"},   32'(bus.tile_wr_en), 0);
    check({tag, "_taddr"},   32'(bus.tile_addr), 0);
    check({tag, "_tdata"},   bus.tile_data, 0);
    check({tag, "_busy"},    32'(bus.busy), 0);
    check({tag, "_done"},    32'(bus.done), 0);
  endtask

  // Monitor: one-hot property every cycle, reads and writes against the scoreboards.
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot", 32'($countones(bus.tile_wr_en) <= 1), 1);
      if (bus.g_rd_en) begin
        check("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          int a;
          a = rd_q.pop_front();
          check("rd_addr", 32'(bus.g_rd_addr), 32'(a));
        end
      end
      if (|bus.tile_wr_en) begin
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          wr_t e;
          logic [NT-1:0] en;
          e  = wr_q.pop_front();
          en = NT'(1) << e.tile;
          $display("[TB] write tile %0d off %0d data %08h", e.tile, e.off, e.data);
          check("wr_en", 32'(bus.tile_wr_en), 32'(en));
          check("wr_addr", 32'(bus.tile_addr), 32'(e.off));
          check("wr_data", bus.tile_data, e.data);
        end
      end
    end
  end

  // One load: launch, optional stall / redundant start / mid-load reset, then check timing.
  task automatic run_load(input int base, input int stall_at, input int stall_len,
                          input int restart_at, input int rst_at);
    int c;
    int reads;
    int stall_rem;
    int n_done;
    int done_cyc;
    int exp_done;
    c = 1; reads = 0; stall_rem = 0; n_done = 0; done_cyc = 0;
    exp_done = MD*MD + 2 + ((stall_at > 0) ? stall_len : 0);
    push_expect(base);
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (c < 400) begin
      bus.stall = (stall_rem > 0);
      bus.start = (c == restart_at);
      bus.base_addr = (c == restart_at) ? AW'(7) : AW'(base);
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (bus.stall) begin
        check("stall_rd_en", 32'(bus.g_rd_en), 0);
        stall_rem--;
      end
      if (bus.g_rd_en) begin
        reads++;
        if (reads == stall_at) stall_rem = stall_len;
      end
      if (bus.done) begin
        if (n_done == 0) done_cyc = c;
        n_done++;
      end
      check("busy", 32'(bus.busy), 32'(c < exp_done));
      check("done", 32'(bus.done), 32'(c == exp_done));
      @(posedge clk); #1;
      c++;
      if (c - 1 == rst_at) begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_idle_outputs("post_rst");
          @(posedge clk); #1;
        end
        $display("[TB] load base %0d aborted by reset in cycle %0d", base, rst_at);
        return;
      end
      if (n_done > 0 && c > done_cyc + 1) break;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("done_count", 32'(n_done), 1);
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("rd_left", 32'(rd_q.size()), 0);
    check("wr_left", 32'(wr_q.size()), 0);
    rd_q.delete();
    wr_q.delete();
    $display("[TB] load base %0d stall_at %0d restart_at %0d: done in cycle %0d", base, stall_at,
             restart_at, done_cyc);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    mon_en = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hABC0_0000 | 32'(i);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = AW'(5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("idle");
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_load(0,   0,  0,  0,   0);
    run_load(256, 0,  0,  0,   0);
    run_load(0,   40, 10, 0,   0);
    run_load(0,   0,  0,  100, 0);
    run_load(0,   0,  0,  0,   50);
    run_load(0,   0,  0,  0,   0);
    run_load(300, 0,  0,  0,   0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/tile_scatter_loader.md
Name: tile_scatter_loader

Overview:
- Sequential stage between the global input/weight buffer (global_bram) and the bank of tiled BRAMs.
- On a start pulse, reads one MAT_DIM x MAT_DIM row-major matrix from the global buffer, beginning at a base address.
- Scatters each word into the TILE_SIZE x TILE_SIZE tile BRAM that owns it, using a one-hot write enable per tile BRAM and a local tile address.
- One instance loads the 16 input tile BRAMs; a second instance loads the 16 weight tile BRAMs.

Parameters:
- DATA_WIDTH, 32, word width of global and tile data.
- TILE_SIZE, 4, tile edge length in words.
- MAT_DIM, 16, matrix edge length in words. Must be a multiple of TILE_SIZE.
- NUM_TILES, 16, number of tile BRAMs. Must equal (MAT_DIM/TILE_SIZE)^2.
- ADDR_WIDTH, 9, global buffer address width (512 words).
- TADDR_WIDTH, 4, tile BRAM address width. Must equal clog2(TILE_SIZE^2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  global start address; latched when start is accepted.
- stall  input  1  when high, no new global read is issued.
- g_rd_en  output  1  global buffer read enable.
- g_rd_addr  output  ADDR_WIDTH  global buffer read address.
- g_rd_data  input  DATA_WIDTH  global read data; valid exactly 1 cycle after g_rd_en.
- tile_wr_en  output  NUM_TILES  one-hot tile BRAM write enable.
- tile_addr  output  TADDR_WIDTH  word offset inside the selected tile.
- tile_data  output  DATA_WIDTH  write data to the tile BRAMs.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last tile write.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. Outputs g_rd_en, g_rd_addr, tile_wr_en, tile_addr, tile_data, busy and done all go to 0. Row/col counters and the pipeline valid flag clear. Reset mid-load aborts immediately; no writes occur after the reset edge.
- States:
  - IDLE: start=1 latches base_addr, clears row=col=0, sets busy=1, and moves to READ.
  - READ: each cycle with stall=0, assert g_rd_en with g_rd_addr = base + row*MAT_DIM + col, then advance col. When col wraps (MAT_DIM-1 -> 0), row increments. The issue with row=col=MAT_DIM-1 moves the FSM to DRAIN.
  - DRAIN: a single cycle that writes the final word, then moves to DONE.
  - DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Read/write pipeline:
  - Each issued read records its tile index and offset in a 1-deep pipeline register with a valid flag.
  - On the next cycle, tile_wr_en[tile]=1, tile_addr=offset and tile_data=g_rd_data, combinationally from g_rd_data gated by the valid flag. Nothing else drives tile_data in that cycle.
- Index mapping:
  - tile = (row/TILE_SIZE)*(MAT_DIM/TILE_SIZE) + col/TILE_SIZE
  - offset = (row%TILE_SIZE)*TILE_SIZE + col%TILE_SIZE
  - Implement with sub-counters; no dividers.
- Stall:
  - stall=1 in READ: g_rd_en=0 and counters hold.
  - A read issued in the previous cycle is still written, so stall never drops data.
  - stall is ignored in IDLE, DRAIN and DONE.
- Latency (stall-free): start accepted at edge E0. Reads occur in cycles 1..MAT_DIM^2, writes in cycles 2..MAT_DIM^2+1, done in cycle MAT_DIM^2+2. Default: done in cycle 258.
- start while busy is ignored. Simultaneous rst and start: rst wins.
- Address arithmetic is modulo 2^ADDR_WIDTH: base + 255 > 511 wraps to low addresses, and this is not an error.
- At most one bit of tile_wr_en is high in any cycle. tile_wr_en is all-zero whenever no write is occurring.

Test Plan:
- Reset then start with base_addr=0, global mem[i]=i, MAT_DIM=16, no stall -> 256 writes. Expect: addr 0 -> tile 0 off 0; addr 5 -> tile 1 off 1; addr 17 -> tile 0 off 5; addr 255 -> tile 15 off 15. done pulses once in cycle 258 after acceptance; busy is high for cycles 1..257.
- start with base_addr=256 -> first g_rd_addr=256, last g_rd_addr=511. tile 3 off 0 receives mem[268].
- stall=1 for 10 cycles after the 40th read -> no g_rd_en during the stall. The 40th word is still written. All 256 words land correctly; done arrives 10 cycles later (cycle 268).
- start pulsed again in cycle 100 of a load -> ignored; no address restart; a single done.
- rst asserted in cycle 50 -> from the next edge all outputs are 0 with no further writes. A fresh start with base_addr=0 loads the full matrix correctly.
- base_addr=300 -> reads wrap: word index 211 reads address 511, and word index 212 reads address 0. Check the one-hot property of tile_wr_en on every cycle.
